// File: rtl/scan_c2h_packer.sv
// Packs framed 32-bit scan samples into 128-bit beats for the C2H0 AXIS source stage and pads
// each frame to a whole number of BLK_BEATS beats, so downstream tlast marks the true frame end.
module scan_c2h_packer #(
  parameter int unsigned BLK_BEATS = 256,
  parameter logic [31:0] PAD_WORD  = 32'hDEAD_BEEF
) (
  input  logic         usr_clk,
  input  logic         usr_rst_n,
  input  logic         clr_i,
  input  logic [31:0]  scan_data_i,
  input  logic         scan_valid_i,
  input  logic         scan_start_i,
  input  logic         scan_stop_i,
  output logic [127:0] pcie_data_o,
  output logic         pcie_valid_o,
  output logic         pcie_start_o,
  output logic         pcie_stop_o,
  output logic         busy_o,
  output logic [15:0]  drop_cnt_o,
  output logic [31:0]  frame_beats_o
);

  localparam int unsigned BlkW = $clog2(BLK_BEATS);

  typedef enum logic [1:0] {StIdle, StPack, StPad, StFin} state_e;

  state_e         state_q, state_d;
  logic [1:0]     lane_q, lane_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic [95:0]    buf_q, buf_d;
  logic           first_q, first_d;
  logic [127:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           start_q, start_d;
  logic           stop_q, stop_d;
  logic           busy_q;
  logic [15:0]    drop_q, drop_d;
  logic [31:0]    frame_q, frame_d;

  logic           pack_en;
  logic           clr_frame;
  logic           beat;
  logic [2:0]     fill;
  logic [1:0]     lane_base;
  logic [127:0]   beat_data;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    blk_d     = blk_q;
    buf_d     = buf_q;
    first_d   = first_q;
    drop_d    = drop_q;
    stop_d    = 1'b0;
    start_d   = 1'b0;
    pack_en   = 1'b0;
    clr_frame = 1'b0;
    beat      = 1'b0;
    fill      = 3'd0;
    lane_base = lane_q;
    beat_data = {4{PAD_WORD}};

    unique case (state_q)
      StIdle: begin
        if (scan_start_i) begin
          clr_frame = 1'b1;
          first_d   = 1'b1;
          blk_d     = '0;
          lane_base = 2'd0;
          lane_d    = 2'd0;
          // An empty frame opened and closed in one cycle only produces the stop pulse.
          if (scan_stop_i && !scan_valid_i) begin
            stop_d = 1'b1;
          end else begin
            pack_en = 1'b1;
          end
        end
      end
      StPack: pack_en = 1'b1;
      StPad: begin
        beat  = 1'b1;
        blk_d = blk_q + {{(BlkW-1){1'b0}}, 1'b1};
        if (blk_d == '0) state_d = StFin;
      end
      StFin: begin
        stop_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (pack_en) begin
      fill = {1'b0, lane_base} + {2'b00, scan_valid_i};
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < lane_base) beat_data[i*32 +: 32] = buf_q[i*32 +: 32];
        if (scan_valid_i && (2'(i) == lane_base)) begin
          beat_data[i*32 +: 32] = scan_data_i;
          buf_d[i*32 +: 32]     = scan_data_i;
        end
      end
      if (scan_valid_i && (lane_base == 2'd3)) beat_data[127:96] = scan_data_i;

      // Lanes at or above fill keep PAD_WORD, which forms the partial beat on stop.
      beat   = (fill == 3'd4) || (scan_stop_i && (fill != 3'd0));
      lane_d = scan_stop_i ? 2'd0 : fill[1:0];
      blk_d  = blk_d + {{(BlkW-1){1'b0}}, beat};
      if (scan_stop_i) begin
        state_d = (blk_d != '0) ? StPad : StFin;
      end else begin
        state_d = StPack;
      end
    end

    if ((state_q == StPad || state_q == StFin) && scan_valid_i && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    start_d = beat && first_d;
    if (beat) first_d = 1'b0;

    valid_d = beat;
    data_d  = beat ? beat_data : '0;
    frame_d = (clr_frame ? 32'd0 : frame_q) + {31'd0, beat};
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      blk_q   <= '0;
      buf_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      frame_q <= '0;
    end else if (clr_i) begin
      state_q <= StIdle;
      lane_q  <= '0;
      blk_q   <= '0;
      buf_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      blk_q   <= blk_d;
      buf_q   <= buf_d;
      first_q <= first_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= (state_d != StIdle);
      drop_q  <= drop_d;
      frame_q <= frame_d;
    end
  end

  assign pcie_data_o   = data_q;
  assign pcie_valid_o  = valid_q;
  assign pcie_start_o  = start_q;
  assign pcie_stop_o   = stop_q;
  assign busy_o        = busy_q;
  assign drop_cnt_o    = drop_q;
  assign frame_beats_o = frame_q;

endmodule

// File: tb/tb_scan_c2h_packer.sv
// Bench for scan_c2h_packer: an IDLE/control vector table, then directed and random frames
// scored against a frame-level model of expected beats, pads, stop pulses and drop counts.
module tb_scan_c2h_packer;

  localparam int unsigned Blk    = 256;
  localparam logic [31:0] Pad    = 32'hDEAD_BEEF;
  localparam int          MaxCyc = 20000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [31:0]  sdata = '0;
  logic         svalid = 1'b0;
  logic         sstart = 1'b0;
  logic         sstop = 1'b0;
  logic [127:0] pdata;
  logic         pvalid, pstart, pstop, busy;
  logic [15:0]  drop_cnt;
  logic [31:0]  frame_beats;

  scan_c2h_packer #(.BLK_BEATS(Blk), .PAD_WORD(Pad)) dut (
    .usr_clk       (clk),
    .usr_rst_n     (rst_n),
    .clr_i         (clr),
    .scan_data_i   (sdata),
    .scan_valid_i  (svalid),
    .scan_start_i  (sstart),
    .scan_stop_i   (sstop),
    .pcie_data_o   (pdata),
    .pcie_valid_o  (pvalid),
    .pcie_start_o  (pstart),
    .pcie_stop_o   (pstop),
    .busy_o        (busy),
    .drop_cnt_o    (drop_cnt),
    .frame_beats_o (frame_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected output stream indexed by cycle.
  bit           exp_valid[MaxCyc];
  bit           exp_start[MaxCyc];
  bit           exp_stop[MaxCyc];
  logic [127:0] exp_data[MaxCyc];
  int           exp_fb[MaxCyc];
  bit           mon_en = 1'b0;

  int           m_lanes;
  int           m_beats;
  int           m_drop;
  logic [127:0] m_cur;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  task automatic mon_check();
    int c;
    c = cyc;
    if (c >= MaxCyc) return;
    checks++;
    if (pvalid !== exp_valid[c] || pstart !== exp_start[c] || pstop !== exp_stop[c] ||
        (exp_valid[c] && pdata !== exp_data[c]) || (exp_stop[c] && frame_beats !== exp_fb[c]))
    begin
      errors++;
      $display("FAIL stream cyc=%0d got v=%b s=%b p=%b d=%h fb=%0d want v=%b s=%b p=%b d=%h fb=%0d",
               c, pvalid, pstart, pstop, pdata, frame_beats,
               exp_valid[c], exp_start[c], exp_stop[c], exp_data[c], exp_fb[c]);
    end
  endtask

  // Applies inputs for one cycle, then checks that cycle's outputs at the falling edge.
  task automatic drive(input bit v, input logic [31:0] d, input bit st, input bit sp,
                       input bit cl, output int t);
    @(posedge clk);
    #1;
    svalid = v;
    sdata  = d;
    sstart = st;
    sstop  = sp;
    clr    = cl;
    t      = cyc;
    @(negedge clk);
    if (mon_en) mon_check();
  endtask

  task automatic model_reset();
    m_lanes = 0;
    m_beats = 0;
    m_cur   = {4{Pad}};
  endtask

  task automatic expect_beat(input int c, input logic [127:0] d);
    if (c < MaxCyc) begin
      exp_valid[c] = 1'b1;
      exp_data[c]  = d;
      exp_start[c] = (m_beats == 0);
    end
    m_beats++;
  endtask

  task automatic accept(input int t, input logic [31:0] d);
    m_cur[m_lanes*32 +: 32] = d;
    m_lanes++;
    if (m_lanes == 4) begin
      expect_beat(t + 1, m_cur);
      m_lanes = 0;
      m_cur   = {4{Pad}};
    end
  endtask

  // gap<0: random gaps with ignored start pulses; junk<0: random samples in the drop window.
  task automatic run_frame(input int n, input int gap, input bit on_start, input int junk,
                           input bit seq);
    int t;
    int tt;
    int p;
    int g;
    bit jv;
    logic [31:0] d;
    model_reset();
    if (n == 0) begin
      drive(1'b0, $urandom, 1'b1, 1'b1, 1'b0, t);
      exp_stop[t+1] = 1'b1;
      exp_fb[t+1]   = 0;
      drive(1'b0, $urandom, 1'b0, 1'b0, 1'b0, tt);
      chk("empty_frame_busy", {127'd0, busy}, 128'd0);
      return;
    end
    if (!on_start) drive(1'b0, $urandom, 1'b1, 1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      if (i > 0 || !on_start) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) begin
          drive(1'b0, $urandom, (gap < 0) && ($urandom_range(0, 5) == 0), 1'b0, 1'b0, t);
        end
      end
      d = seq ? 32'(i) : $urandom;
      drive(1'b1, d, (i == 0) && on_start, (i == n - 1), 1'b0, t);
      accept(t, d);
    end
    if (m_lanes != 0) expect_beat(t + 1, m_cur);
    p = t + 2;
    while ((m_beats % Blk) != 0) begin
      expect_beat(p, {4{Pad}});
      p++;
    end
    if (p < MaxCyc) begin
      exp_stop[p] = 1'b1;
      exp_fb[p]   = m_beats;
    end
    for (int k = t + 1; k < p; k++) begin
      jv = (junk < 0) ? 1'($urandom_range(0, 1)) : ((k - t) <= junk);
      drive(jv, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, tt);
      if (jv && m_drop < 65535) m_drop++;
    end
    drive(1'b0, $urandom, 1'b0, 1'b0, 1'b0, tt);
    chk("frame_end_drop_cnt", {112'd0, drop_cnt}, 128'(m_drop));
    chk("frame_end_beats", {96'd0, frame_beats}, 128'(m_beats));
    chk("frame_end_busy", {127'd0, busy}, 128'd0);
    if (junk < 0) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        drive(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, tt);
      end
    end
  endtask

  typedef struct {
    bit v;
    bit st;
    bit sp;
    bit ev;
    bit es;
    bit ep;
    bit eb;
    int ed;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int t;
    // Each row: inputs for one cycle and the outputs expected during that same cycle.
    tbl[0] = '{v: 0, st: 0, sp: 0, ev: 0, es: 0, ep: 0, eb: 0, ed: 0};
    tbl[1] = '{v: 1, st: 0, sp: 0, ev: 0, es: 0, ep: 0, eb: 0, ed: 0};
    tbl[2] = '{v: 0, st: 1, sp: 1, ev: 0, es: 0, ep: 0, eb: 0, ed: 0};
    tbl[3] = '{v: 0, st: 0, sp: 0, ev: 0, es: 0, ep: 1, eb: 0, ed: 0};
    tbl[4] = '{v: 0, st: 1, sp: 0, ev: 0, es: 0, ep: 0, eb: 0, ed: 0};
    tbl[5] = '{v: 0, st: 0, sp: 1, ev: 0, es: 0, ep: 0, eb: 1, ed: 0};
    tbl[6] = '{v: 1, st: 0, sp: 0, ev: 0, es: 0, ep: 0, eb: 1, ed: 0};
    tbl[7] = '{v: 0, st: 0, sp: 0, ev: 0, es: 0, ep: 1, eb: 0, ed: 1};
    tbl[8] = '{v: 0, st: 0, sp: 0, ev: 0, es: 0, ep: 0, eb: 0, ed: 1};

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, t);
    chk("reset_outputs", {pdata, pvalid, pstart, pstop, busy, drop_cnt, frame_beats} , '0);
    chk("reset_data", pdata, 128'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, $urandom, tbl[i].st, tbl[i].sp, 1'b0, t);
      chk($sformatf("tbl%0d_ctl", i), {124'd0, pvalid, pstart, pstop, busy},
          {124'd0, tbl[i].ev, tbl[i].es, tbl[i].ep, tbl[i].eb});
      chk($sformatf("tbl%0d_drop", i), {112'd0, drop_cnt}, 128'(tbl[i].ed));
      chk($sformatf("tbl%0d_fb", i), {96'd0, frame_beats}, 128'd0);
    end
    m_drop = 1;
    mon_en = 1'b1;

    run_frame(1024, 0, 1'b1, 0, 1'b1);    // contiguous 0..1023, no pad
    run_frame(6, 0, 1'b1, 0, 1'b0);       // full + partial beat, 254 pads
    run_frame(8, 2, 1'b0, 0, 1'b0);       // valid every 3rd cycle
    run_frame(6, 0, 1'b1, 10, 1'b0);      // 10 samples dropped during PAD

    // Abort a frame with clr_i while beat 100 is on the bus.
    model_reset();
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, t);
    accept(t, 32'd0);
    for (int i = 1; i < 404; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, t);
      accept(t, 32'(i));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, t);
    chk("clr_beat100_fb", {96'd0, frame_beats}, 128'd101);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, t);
    chk("clr_after_state", {96'd0, busy, pvalid, pstop, drop_cnt, frame_beats[12:0]}, 128'd0);
    m_drop = 0;
    run_frame(6, 0, 1'b1, 0, 1'b0);

    run_frame(0, 0, 1'b1, 0, 1'b0);       // start+stop, no sample
    run_frame(1, 0, 1'b1, 0, 1'b0);       // start+stop with one sample

    for (int f = 0; f < 14; f++) begin
      run_frame(int'($urandom_range(0, 40)), -1, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
